// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between fetch and data requesters
//
// Serialises instruction-fetch and load/store transactions onto one shared
// memory port. A grant is issued from IDLE only while start is high; the
// winner's address/we/wdata are registered onto the mem_* port and held until
// the memory answers with mem_valid_mem2arb. That answer is forwarded
// combinationally to the owning requester as a one-cycle valid pulse.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, data beats fetch when both request
//   defined   : alternate between requesters when both request
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     grant enable
//   inst_request_core2arb     fetch request (held until inst_valid_arb2core)
//   inst_addr_core2arb        fetch word address
//   inst_valid_arb2core       fetch completion pulse
//   inst_arb2core             fetched word, 0 unless valid
//   data_request_core2arb     load/store request (held until data_valid_arb2core)
//   data_we_core2arb          1 = store
//   data_addr_core2arb        data word address
//   data_wdata_core2arb       store data
//   data_valid_arb2core       data completion pulse
//   data_rdata_arb2core       load data, 0 unless valid
//   mem_request_arb2mem       registered memory request
//   mem_we_arb2mem            registered write enable
//   mem_addr_arb2mem          registered address
//   mem_wdata_arb2mem         registered write data
//   mem_valid_mem2arb         memory completion pulse
//   mem_rdata_mem2arb         memory read data
//   grant_data                high while a data transaction owns the port

module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  inst_request_core2arb,
  input  logic [ADDR_WIDTH-1:0] inst_addr_core2arb,
  output logic                  inst_valid_arb2core,
  output logic [DATA_WIDTH-1:0] inst_arb2core,
  input  logic                  data_request_core2arb,
  input  logic                  data_we_core2arb,
  input  logic [ADDR_WIDTH-1:0] data_addr_core2arb,
  input  logic [DATA_WIDTH-1:0] data_wdata_core2arb,
  output logic                  data_valid_arb2core,
  output logic [DATA_WIDTH-1:0] data_rdata_arb2core,
  output logic                  mem_request_arb2mem,
  output logic                  mem_we_arb2mem,
  output logic [ADDR_WIDTH-1:0] mem_addr_arb2mem,
  output logic [DATA_WIDTH-1:0] mem_wdata_arb2mem,
  input  logic                  mem_valid_mem2arb,
  input  logic [DATA_WIDTH-1:0] mem_rdata_mem2arb,
  output logic                  grant_data
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INST_BUSY = 2'd1,
    DATA_BUSY = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic win_inst;
  logic win_data;
  logic data_wins;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = data won the previous grant, 0 = fetch won (reset value).
  logic last_grant;

  // On contention, the side that did not win last time gets the port.
  assign data_wins = data_request_core2arb &&
                     (!inst_request_core2arb || !last_grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b0;
    end else if (win_data) begin
      last_grant <= 1'b1;
    end else if (win_inst) begin
      last_grant <= 1'b0;
    end
  end
`else
  // Data access belongs to the older instruction, so it always wins.
  assign data_wins = data_request_core2arb;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next          = state;
    win_inst            = 1'b0;
    win_data            = 1'b0;
    inst_valid_arb2core = 1'b0;
    inst_arb2core       = '0;
    data_valid_arb2core = 1'b0;
    data_rdata_arb2core = '0;

    case (state)
      IDLE: begin
        if (start) begin
          if (data_wins) begin
            win_data   = 1'b1;
            state_next = DATA_BUSY;
          end else if (inst_request_core2arb) begin
            win_inst   = 1'b1;
            state_next = INST_BUSY;
          end
        end
      end
      INST_BUSY: begin
        if (mem_valid_mem2arb) begin
          inst_valid_arb2core = 1'b1;
          inst_arb2core       = mem_rdata_mem2arb;
          state_next          = IDLE;
        end
      end
      DATA_BUSY: begin
        if (mem_valid_mem2arb) begin
          data_valid_arb2core = 1'b1;
          data_rdata_arb2core = mem_rdata_mem2arb;
          state_next          = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Memory port registers: loaded on grant, frozen while busy, cleared when
  // the transaction completes so the port reads as quiet in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_request_arb2mem <= 1'b0;
      mem_we_arb2mem      <= 1'b0;
      mem_addr_arb2mem    <= '0;
      mem_wdata_arb2mem   <= '0;
    end else if (win_data) begin
      mem_request_arb2mem <= 1'b1;
      mem_we_arb2mem      <= data_we_core2arb;
      mem_addr_arb2mem    <= data_addr_core2arb;
      mem_wdata_arb2mem   <= data_wdata_core2arb;
    end else if (win_inst) begin
      mem_request_arb2mem <= 1'b1;
      mem_we_arb2mem      <= 1'b0;
      mem_addr_arb2mem    <= inst_addr_core2arb;
      mem_wdata_arb2mem   <= '0;
    end else if ((state != IDLE) && mem_valid_mem2arb) begin
      mem_request_arb2mem <= 1'b0;
      mem_we_arb2mem      <= 1'b0;
      mem_addr_arb2mem    <= '0;
      mem_wdata_arb2mem   <= '0;
    end
  end

  assign grant_data = (state == DATA_BUSY);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one shared single-ported memory between the instruction-fetch requester and the data-access requester of the five-stage core. Sits between the core's fetch/load-store ports and the memory model, and runs a grant state machine that serialises transactions on the shared port. Each completed transaction is signalled back to the owning requester with a one-cycle valid pulse, so the fetch stage can keep using `!valid` as its stall condition.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, word address width (the requester supplies word addresses; no shifting here)
- `DATA_WIDTH`, 32, instruction/data word width

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  grants issued only while high
- `inst_request_core2arb`  in  1  fetch request, held until `inst_valid_arb2core`
- `inst_addr_core2arb`  in  ADDR_WIDTH  fetch word address
- `inst_valid_arb2core`  out  1  one-cycle fetch completion pulse
- `inst_arb2core`  out  DATA_WIDTH  fetched instruction, qualified by valid
- `data_request_core2arb`  in  1  data request, held until `data_valid_arb2core`
- `data_we_core2arb`  in  1  1 = store, 0 = load
- `data_addr_core2arb`  in  ADDR_WIDTH  data word address
- `data_wdata_core2arb`  in  DATA_WIDTH  store data
- `data_valid_arb2core`  out  1  one-cycle data completion pulse
- `data_rdata_arb2core`  out  DATA_WIDTH  load data, qualified by valid
- `mem_request_arb2mem`  out  1  memory request, held until `mem_valid_mem2arb`
- `mem_we_arb2mem`  out  1  write enable
- `mem_addr_arb2mem`  out  ADDR_WIDTH  latched address
- `mem_wdata_arb2mem`  out  DATA_WIDTH  latched write data
- `mem_valid_mem2arb`  in  1  memory completion pulse
- `mem_rdata_mem2arb`  in  DATA_WIDTH  read data, qualified by valid
- `grant_data`  out  1  1 while a data transaction owns the port

## Operation
- FSM states: IDLE, INST_BUSY, DATA_BUSY.
- IDLE with `start`=1 and at least one request:
  - Select a winner (priority below).
  - Latch address, we and wdata into the `mem_*` registers.
  - Go to the winner's BUSY state.
- Inst grant forces `mem_we_arb2mem`=0 and `mem_wdata_arb2mem`=0.
- IDLE with `start`=0: no grant regardless of requests.
- BUSY state:
  - `mem_request_arb2mem`=1 and the `mem_*` outputs are held stable.
  - Requester inputs are ignored.
- On `mem_valid_mem2arb`=1 in BUSY:
  - The owner's valid output is driven high combinationally, for that cycle only.
  - `mem_rdata_mem2arb` is forwarded to the owner's data output.
  - The FSM returns to IDLE.
- For a store, `data_rdata_arb2core` carries whatever memory returns; the core ignores it.
- The non-owner's valid output is always 0.
- Both data outputs are 0 whenever their valid is 0.
- `mem_valid_mem2arb` in IDLE is ignored (no valid pulse, no state change).
- Requester contract: a request still high in the cycle after its valid pulse is a new request.
- `grant_data` = (state == DATA_BUSY).
- Reset, including mid-transaction:
  - State returns to IDLE, `mem_request_arb2mem`=0, the fixed-priority outcome is restored, and all outputs go to 0.
  - The memory shares `rst`; no response from an aborted transaction is forwarded.

## Timing
- Reset values: all outputs 0, state IDLE.
- Request seen in IDLE at cycle N → `mem_request_arb2mem`=1 from cycle N+1.
- Memory responds at cycle N+1+L (L ≥ 0) → core valid pulses at cycle N+1+L.
- Minimum latency: 1 cycle (request to valid).
- Maximum throughput: one transaction per 2 cycles, because the FSM spends at least one cycle in IDLE between transactions.
- No combinational path from requester inputs to `mem_*` outputs; all `mem_*` outputs are registered.
- The only combinational paths are `mem_valid_mem2arb`/`mem_rdata_mem2arb` → core valid/data outputs.

## Configuration
- `ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: data wins whenever both requests are high in IDLE, because the data access is the older instruction.
  - Sustained data requests can starve fetch.
- `ARB_ROUND_ROBIN_EN` defined:
  - A 1-bit `last_grant` register (reset to inst) records the last winner.
  - When both requests are high, the requester that did not win last is granted.
  - A single request is granted immediately.
  - `last_grant` updates on every grant.

## Test plan
- Single fetch: `start`=1, inst req at addr 0x10, memory L=0 with rdata 0x00500093 → `mem_request_arb2mem`=1, `mem_addr_arb2mem`=0x10, `mem_we_arb2mem`=0 next cycle; `inst_valid_arb2core` pulses that same cycle with `inst_arb2core`=0x00500093.
- Store with L=3: data req we=1, addr 0x40, wdata 0xDEADBEEF → `mem_*` outputs held stable for 4 cycles; one `data_valid_arb2core` pulse on the memory's valid; `inst_valid_arb2core` stays 0.
- Simultaneous requests held high for 3 transactions:
  - Macro off: data, data, data.
  - Macro on: data, inst, data (first arbitration has `last_grant`=inst, so data wins first).
- `start`=0 with both requests high for 5 cycles → `mem_request_arb2mem` stays 0; raising `start` produces a grant on the next cycle.
- `rst` asserted in DATA_BUSY while the memory is stalled → next cycle: state IDLE, all outputs 0; a later `mem_valid_mem2arb` pulse produces no core valid pulse.
- Back-to-back fetches to 0x0, 0x1, 0x2 with L=0 → valid pulses on cycles 1, 3, 5 with matching addresses on `mem_addr_arb2mem`.
